pc_fetch_unit: RTL

- Program-counter and instruction-fetch stage. Owns the architectural fetch PC and issues requests to instruction memory through a req/ack handshake.
- Presents fetched {pc, instr} to decode through a single-entry valid/ready buffer.
- Consumes the redirect (branch_taken, branch_addr) produced by the branch address calculator downstream.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/pc_fetch_unit_if.sv | 26 ++
 rtl/pc_fetch_unit.sv | 135 +++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the program-counter / instruction-fetch stage.
//   fetch_state_t : fetch FSM states (IDLE, BUSY, DROP)
//   INSTR_BYTES   : PC increment per sequential fetch
//   NOP_INSTR     : instruction word shown by the output buffer after reset
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    localparam int unsigned INSTR_BYTES = 4;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory req/ack channel plus the
// valid/ready channel towards decode.
//   master : fetch unit side (drives imem_req/imem_addr, if_valid/if_pc/if_instr)
//   slave  : memory / decode side (drives imem_ack/imem_data, if_ready)
interface pc_fetch_unit_if #(
    parameter int unsigned WordSize = 32
);
    logic                imem_req;
    logic [WordSize-1:0] imem_addr;
    logic                imem_ack;
    logic [WordSize-1:0] imem_data;
    logic                if_valid;
    logic                if_ready;
    logic [WordSize-1:0] if_pc;
    logic [WordSize-1:0] if_instr;

    modport master (
        output imem_req, imem_addr, if_valid, if_pc, if_instr,
        input  imem_ack, imem_data, if_ready
    );

    modport slave (
        input  imem_req, imem_addr, if_valid, if_pc, if_instr,
        output imem_ack, imem_data, if_ready
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program-counter and instruction-fetch stage.
// Owns the fetch PC, issues requests to instruction memory over a req/ack
// handshake and presents {pc, instr} to decode through a single-entry
// valid/ready buffer. Redirects come from the downstream branch address
// calculator and take priority over ack and stall.
// Ports:
//   clk, rstn     : clock, asynchronous active-low reset
//   stall         : hazard stall, blocks starting a new fetch
//   branch_taken  : redirect strobe; branch_addr is the target
//   bus (master)  : imem_req/imem_addr/imem_ack/imem_data and
//                   if_valid/if_ready/if_pc/if_instr
//   misalign_err  : sticky misaligned-redirect flag
// Build option: FETCH_MISALIGN_CHECK_EN enables redirect alignment checking
// (target forced to word alignment, misalign_err set). Without it the target
// is used as-is and misalign_err is tied low.
module pc_fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned         WordSize    = 32,
    parameter logic [WordSize-1:0] ResetVector = '0
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                stall,
    input  logic                branch_taken,
    input  logic [WordSize-1:0] branch_addr,
    pc_fetch_unit_if.master     bus,
    output logic                misalign_err
);

    fetch_state_t        state_q, state_d;
    logic [WordSize-1:0] pc_q, pc_d;
    logic [WordSize-1:0] addr_q, addr_d;
    logic                valid_q, valid_d;
    logic [WordSize-1:0] if_pc_q, if_pc_d;
    logic [WordSize-1:0] if_instr_q, if_instr_d;
    logic [WordSize-1:0] redirect_pc;
    logic                room;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic misalign_q;

    assign redirect_pc = {branch_addr[WordSize-1:2], 2'b00};

    // Every branch_taken is applied as a redirect in all states.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            misalign_q <= 1'b0;
        end else if (branch_taken && (branch_addr[1:0] != 2'b00)) begin
            misalign_q <= 1'b1;
        end
    end

    assign misalign_err = misalign_q;
`else
    assign redirect_pc  = branch_addr;
    assign misalign_err = 1'b0;
`endif

    // A fetch may start only when its result will have somewhere to land.
    assign room = !valid_q || bus.if_ready;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        addr_d     = addr_q;
        if_pc_d    = if_pc_q;
        if_instr_d = if_instr_q;
        // Buffer drains when decode takes it; overridden by load/flush below.
        valid_d    = valid_q && !bus.if_ready;

        unique case (state_q)
            IDLE: begin
                if (branch_taken) begin
                    pc_d    = redirect_pc;
                    valid_d = 1'b0;
                end else if (room && !stall) begin
                    addr_d  = pc_q;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (branch_taken) begin
                    pc_d    = redirect_pc;
                    valid_d = 1'b0;
                    // Without ack the request is still in flight and its data is stale.
                    state_d = bus.imem_ack ? IDLE : DROP;
                end else if (bus.imem_ack) begin
                    if_pc_d    = addr_q;
                    if_instr_d = bus.imem_data;
                    valid_d    = 1'b1;
                    pc_d       = pc_q + WordSize'(INSTR_BYTES);
                    state_d    = IDLE;
                end
            end
            DROP: begin
                if (branch_taken) begin
                    pc_d    = redirect_pc;
                    valid_d = 1'b0;
                end
                if (bus.imem_ack) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            pc_q       <= ResetVector;
            addr_q     <= '0;
            valid_q    <= 1'b0;
            if_pc_q    <= '0;
            if_instr_q <= WordSize'(NOP_INSTR);
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            addr_q     <= addr_d;
            valid_q    <= valid_d;
            if_pc_q    <= if_pc_d;
            if_instr_q <= if_instr_d;
        end
    end

    assign bus.imem_req  = (state_q == BUSY) || (state_q == DROP);
    assign bus.imem_addr = addr_q;
    assign bus.if_valid  = valid_q;
    assign bus.if_pc     = if_pc_q;
    assign bus.if_instr  = if_instr_q;

endmodule
